// File: rtl/gl_fetch_stream_pkg.sv
// Shared constants for the GL command-stream front end: opcodes, packet
// lengths and the default MULTMATRIX header used by the macro rewrite.
package gl_fetch_stream_pkg;

    localparam logic [7:0] OP_VERTEX     = 8'h03;
    localparam logic [7:0] OP_COLOR      = 8'h04;
    localparam logic [7:0] OP_JMP        = 8'h06;
    localparam logic [7:0] OP_MULTMATRIX = 8'h11;
    localparam logic [7:0] OP_LOADMATRIX = 8'h13;
    localparam logic [7:0] OP_ROTATE     = 8'h16;
    localparam logic [7:0] OP_SCALE      = 8'h17;
    localparam logic [7:0] OP_TRANSLATE  = 8'h18;
    localparam logic [7:0] OP_VIEWPORT   = 8'h19;
    localparam logic [7:0] OP_FRUSTUM    = 8'h1A;
    localparam logic [7:0] OP_ORTHO      = 8'h1B;

    // Packet lengths including the header word
    localparam logic [4:0] LEN_1   = 5'd1;
    localparam logic [4:0] LEN_VTX = 5'd4;
    localparam logic [4:0] LEN_VP  = 5'd5;
    localparam logic [4:0] LEN_MAT = 5'd17;

    localparam logic [31:0] MULT_HDR_DEF = 32'h80001011;

endpackage

// File: rtl/gl_fetch_stream_cmd_len.sv
// Combinational opcode decode: packet length, transform-macro flag, JMP flag.
module gl_fetch_stream_cmd_len
    import gl_fetch_stream_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [4:0] len,
    output logic       is_macro,
    output logic       is_jmp
);

    // Length table; unknown opcodes are single-word packets
    always_comb begin
        len      = LEN_1;
        is_macro = 1'b0;
        is_jmp   = 1'b0;
        case (opcode)
            OP_VERTEX, OP_COLOR:                  len = LEN_VTX;
            OP_MULTMATRIX, OP_LOADMATRIX:         len = LEN_MAT;
            OP_ROTATE, OP_SCALE, OP_TRANSLATE,
            OP_FRUSTUM, OP_ORTHO: begin
                len      = LEN_MAT;
                is_macro = 1'b1;
            end
            OP_VIEWPORT:                          len = LEN_VP;
            OP_JMP:                               is_jmp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/gl_fetch_stream.sv
// Command-stream fetch unit: reads one header per packet from the command
// BRAM, sizes the packet, optionally rewrites transform macros, follows JMP
// and redirect, and hands the header to gl_decode over valid/ready.
module gl_fetch_stream
    import gl_fetch_stream_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               ADDR_W      = 16,
    parameter int               TEXT_START  = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               RD_LAT      = 1,
    parameter int               MACRO_EN    = 1,
    parameter logic [WIDTH-1:0] MULT_HDR    = WIDTH'(MULT_HDR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_opnd_addr,
    output logic [4:0]        out_opnd_cnt,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_CAPT, ST_ISSUE
    } state_t;

    localparam logic [ADDR_W-1:0] TS_ADDR   = ADDR_W'(TEXT_START);
    // WAIT covers RD_LAT-1 cycles; the counter runs down to zero inclusive
    localparam logic [1:0]        WAIT_INIT = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] cap_next;
    logic [1:0]        wait_cnt;
    logic [4:0]        len;
    logic              is_macro;
    logic              is_jmp;

    gl_fetch_stream_cmd_len u_cmd_len (
        .opcode   (mem_rdata[7:0]),
        .len      (len),
        .is_macro (is_macro),
        .is_jmp   (is_jmp)
    );

    assign mem_addr = pc;
    assign busy     = (state != ST_IDLE);

    // Successor address of the header being captured; JMP field zero-extends
    // or truncates to ADDR_W and the sum wraps modulo 2^ADDR_W
    always_comb begin
        if (is_jmp)
            cap_next = TS_ADDR + ADDR_W'(mem_rdata >> 8);
        else
            cap_next = pc + ADDR_W'(len);
    end

    // Fetch FSM: reset beats redirect, redirect beats normal sequencing
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            pc            <= TS_ADDR;
            next_pc       <= TS_ADDR;
            wait_cnt      <= '0;
            mem_en        <= 1'b0;
            out_valid     <= 1'b0;
            out_inst      <= RESET_VALUE;
            out_pc        <= '0;
            out_opnd_addr <= '0;
            out_opnd_cnt  <= '0;
        end else if (redirect) begin
            // In-flight read data is dropped simply because we restart in REQ
            state     <= ST_REQ;
            pc        <= redirect_addr;
            mem_en    <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state  <= ST_REQ;
                        mem_en <= 1'b1;
                    end
                end
                ST_REQ: begin
                    mem_en <= 1'b0;
                    if (RD_LAT > 1) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= ST_CAPT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0)
                        state <= ST_CAPT;
                    else
                        wait_cnt <= wait_cnt - 2'd1;
                end
                ST_CAPT: begin
                    // Rewrite touches the header word only; sizing uses the original opcode
                    out_inst      <= (MACRO_EN != 0 && is_macro) ? MULT_HDR : mem_rdata;
                    out_pc        <= pc;
                    out_opnd_addr <= pc + ADDR_W'(1);
                    out_opnd_cnt  <= len - 5'd1;
                    next_pc       <= cap_next;
                    out_valid     <= 1'b1;
                    state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        pc        <= next_pc;
                        out_valid <= 1'b0;
                        if (run) begin
                            state  <= ST_REQ;
                            mem_en <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gl_fetch_stream.sv
// Bench for gl_fetch_stream: BRAM model with RD_LAT pipeline, directed
// scenarios followed by randomized run/ready/redirect/reset, all checked by a
// packet-level model that walks the command stream by address.
module tb_gl_fetch_stream;

    localparam int          WIDTH  = 32;
    localparam int          ADDR_W = 8;
    localparam int          TS     = 16;
    localparam int          RD_LAT = 3;
    localparam logic [31:0] RV     = 32'hDEADBEEF;
    localparam logic [31:0] MH     = 32'h80001011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        out_ready = 1'b0;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic [7:0]  out_opnd_addr;
    logic [4:0]  out_opnd_cnt;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gl_fetch_stream #(
        .WIDTH       (WIDTH),
        .ADDR_W      (ADDR_W),
        .TEXT_START  (TS),
        .RESET_VALUE (RV),
        .RD_LAT      (RD_LAT),
        .MACRO_EN    (1),
        .MULT_HDR    (MH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_opnd_addr (out_opnd_addr),
        .out_opnd_cnt  (out_opnd_cnt),
        .busy          (busy)
    );

    // Command BRAM: data appears RD_LAT cycles after mem_en; garbage otherwise
    logic [31:0] mem [256];
    logic [31:0] rd_p [RD_LAT];
    always @(posedge clk) begin
        rd_p[0] <= mem_en ? mem[mem_addr] : $urandom;
        for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
    end
    assign mem_rdata = rd_p[RD_LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packet rules from the opcode table
    function automatic int exp_len(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                                     return 4;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B:  return 17;
            8'h19:                                            return 5;
            default:                                          return 1;
        endcase
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] w);
        case (w[7:0])
            8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: return MH;
            default:                           return w;
        endcase
    endfunction

    function automatic logic [7:0] exp_next(input logic [7:0] pc, input logic [31:0] w);
        if (w[7:0] == 8'h06) return 8'(TS + int'(w[15:8]));
        return 8'(int'(pc) + exp_len(w[7:0]));
    endfunction

    // Monitor / reference model, sampled on the falling edge
    bit          mon_on = 0;
    bit          p_rst = 1, p_redir = 0, p_hs = 0, p_run = 0, p_valid = 0;
    bit          idle = 1, was_idle = 1;
    logic [7:0]  m_pc = 8'(TS);
    logic [31:0] mw;
    int          cyc = 0, last_req = 0, n_hs = 0;

    always @(negedge clk) if (mon_on) begin
        cyc++;
        was_idle = idle;
        idle = p_rst ? 1'b1 : p_redir ? 1'b0 : p_hs ? !p_run : (was_idle ? !p_run : 1'b0);
        if (p_rst) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_inst", out_inst, RV);
            chk("rst_pc", out_pc, 0);
            chk("rst_opnd_addr", out_opnd_addr, 0);
            chk("rst_opnd_cnt", out_opnd_cnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_addr", mem_addr, 8'(TS));
        end else begin
            if (p_redir) begin
                chk("redir_valid", out_valid, 0);
                chk("redir_req", mem_en, 1);
            end else if (p_hs) begin
                chk("hs_next_req", mem_en, p_run);
            end else if (was_idle && !idle) begin
                chk("idle_exit_req", mem_en, 1);
            end
            if (idle) begin
                chk("idle_busy", busy, 0);
                chk("idle_mem_en", mem_en, 0);
                chk("idle_valid", out_valid, 0);
            end else begin
                chk("busy", busy, 1);
            end
            if (mem_en) begin
                chk("req_addr", mem_addr, m_pc);
                last_req = cyc;
            end
            if (out_valid) begin
                mw = mem[m_pc];
                if (!p_valid) chk("latency", cyc - last_req, RD_LAT + 1);
                chk("inst", out_inst, exp_inst(mw));
                chk("pc", out_pc, m_pc);
                chk("opnd_addr", out_opnd_addr, 8'(m_pc + 8'd1));
                chk("opnd_cnt", out_opnd_cnt, exp_len(mw[7:0]) - 1);
                chk("valid_no_req", mem_en, 0);
            end
        end
        // Events that take effect at the coming rising edge
        p_valid = out_valid;
        p_rst   = !reset;
        p_redir = reset && redirect;
        p_hs    = reset && out_valid && out_ready;
        p_run   = run;
        if (!reset) begin
            m_pc = 8'(TS);
        end else begin
            if (out_valid && out_ready) begin
                m_pc = exp_next(m_pc, mem[m_pc]);
                n_hs++;
            end
            if (redirect) m_pc = redirect_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        for (int k = 0; k < max && !out_valid; k++) step();
        chk("wait_valid", out_valid, 1);
    endtask

    task automatic wait_req(input int max);
        for (int k = 0; k < max && !mem_en; k++) step();
        chk("wait_req", mem_en, 1);
    endtask

    logic [7:0] opc [12] = '{8'h03, 8'h04, 8'h06, 8'h11, 8'h13, 8'h16,
                             8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h00};

    initial begin
        logic [31:0] w;
        int k;
        for (int a = 0; a < 256; a++) begin
            w = $urandom;
            k = $urandom_range(0, 11);
            w[7:0] = (k == 11) ? 8'($urandom) : opc[k];
            mem[a] = w;
        end
        // Directed chain from TEXT_START: VERTEX, VIEWPORT, MULTMATRIX, ROTATE, JMP -> 0x40
        mem[8'h10] = 32'h00000003;
        mem[8'h14] = 32'h00000019;
        mem[8'h19] = 32'h00000011;
        mem[8'h2A] = 32'h12345616;
        mem[8'h3B] = 32'h00003006;
        mem[8'h40] = 32'h00000004;
        mem[8'hFE] = 32'hABCDEF03;

        repeat (2) @(posedge clk);
        #1 mon_on = 1;
        step();
        reset = 1; run = 1; out_ready = 1;
        repeat (60) step();

        // Back-pressure: hold ready low in ISSUE, then release
        out_ready = 0;
        wait_valid(30);
        repeat (5) step();
        out_ready = 1;
        repeat (10) step();

        // Redirect while the read is still in flight (WAIT)
        wait_req(30);
        step();
        redirect = 1; redirect_addr = 8'hFE;
        step();
        redirect = 0;
        repeat (30) step();

        // Reset while a header is on offer
        out_ready = 0;
        wait_valid(30);
        reset = 0;
        step();
        reset = 1; out_ready = 1;
        repeat (20) step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            out_ready     = ($urandom_range(0, 9) < 7);
            run           = ($urandom_range(0, 19) != 0);
            redirect      = ($urandom_range(0, 39) == 0);
            redirect_addr = 8'($urandom);
            reset         = ($urandom_range(0, 299) != 0);
            step();
        end
        redirect = 0; reset = 1; run = 1; out_ready = 1;
        repeat (20) step();

        chk("handshakes", n_hs > 200, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
